// File: rtl/nv_nvdla_sdp_core_y_dpgather.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_core_y_dpgather
//
// Width gatherer on the SDP Y datapath. Narrow IW-bit beats are packed into
// one OW = IW*RATIO bit word, with segment 0 as the least-significant slice.
// A beat flagged with inp_last closes the word early. out_mask reports which
// segments hold data. This block is the inverse of the Y-path splitter.
//
// Ports:
//   nvdla_core_clk   core clock
//   nvdla_core_rstn  synchronous active-low reset
//   inp_pvld/prdy    input beat handshake
//   inp_data         IW-bit input beat
//   inp_last         end of stream, qualified by inp_pvld
//   out_pvld/prdy    packed word handshake
//   out_data         OW-bit packed word
//   out_mask         bit k set when segment k holds valid data
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Once valid is raised, the producer holds valid and
// payload stable until that transfer. Ready may depend combinationally on
// the consumer's ready (inp_prdy = !out_pvld | out_prdy).
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_core_y_dpgather #(
    parameter int IW    = 128,
    parameter int RATIO = 4,
    parameter int CW    = 2
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  inp_pvld,
    input  logic [IW-1:0]         inp_data,
    input  logic                  inp_last,
    output logic                  inp_prdy,
    output logic                  out_pvld,
    output logic [IW*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]      out_mask,
    input  logic                  out_prdy
);

    localparam int OW = IW * RATIO;

    logic [CW-1:0]    pack_cnt;
    logic [CW-1:0]    pack_cnt_nxt;
    logic             out_pvld_nxt;
    logic [OW-1:0]    data_nxt;
    logic [RATIO-1:0] mask_nxt;
    logic             inp_acc;
    logic             out_acc;
    logic             word_done;

    // There is a single assembly register. A new beat can enter only when
    // that register is empty, or when it is being drained in this same cycle.
    assign inp_prdy  = !out_pvld || out_prdy;
    assign inp_acc   = inp_pvld && inp_prdy;
    assign out_acc   = out_pvld && out_prdy;
    assign word_done = inp_acc && ((pack_cnt == CW'(RATIO - 1)) || inp_last);

    always_comb begin
        // Draining clears the register, so unfilled segments of a later
        // partial word read as zero. A beat accepted in the same cycle as
        // the drain lands on top of the cleared register. pack_cnt is
        // already 0 in that case, because completion resets it.
        data_nxt     = out_acc ? '0 : out_data;
        mask_nxt     = out_acc ? '0 : out_mask;
        pack_cnt_nxt = pack_cnt;
        out_pvld_nxt = out_acc ? 1'b0 : out_pvld;

        if (inp_acc) begin
            for (int k = 0; k < RATIO; k++) begin
                if (pack_cnt == CW'(k)) begin
                    data_nxt[k*IW +: IW] = inp_data;
                    mask_nxt[k]          = 1'b1;
                end
            end
            pack_cnt_nxt = word_done ? '0 : pack_cnt + CW'(1);
        end

        if (word_done) begin
            out_pvld_nxt = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            out_pvld <= 1'b0;
            pack_cnt <= '0;
            out_mask <= '0;
            out_data <= '0;
        end else begin
            out_pvld <= out_pvld_nxt;
            pack_cnt <= pack_cnt_nxt;
            out_mask <= mask_nxt;
            out_data <= data_nxt;
        end
    end

    // Handshake outputs must never be X once reset has been released.
    a_no_x_ctrl: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !$isunknown(inp_prdy) && !$isunknown(out_pvld));

    // A stalled output word must not change under the consumer.
    a_hold_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (out_pvld && !out_prdy) |=> ($stable(out_data) && $stable(out_mask) && out_pvld));

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_dpgather.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_sdp_core_y_dpgather
//
// Directed bench for the Y-path width gatherer.
// Inputs are driven 1 time unit after the rising edge.
// Handshake readiness is sampled 2 time units after the rising edge.
// Packed words are scored at the falling edge against an expected queue.
// That queue is filled by a small packing model driven from the accepted beats.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_sdp_core_y_dpgather;

    localparam int IW    = 128;
    localparam int RATIO = 4;
    localparam int OW    = IW * RATIO;

    // ---------------- clock / reset ----------------
    logic            clk;
    logic            rstn;
    logic            inp_pvld;
    logic [IW-1:0]   inp_data;
    logic            inp_last;
    logic            inp_prdy;
    logic            out_pvld;
    logic [OW-1:0]   out_data;
    logic [RATIO-1:0] out_mask;
    logic            out_prdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nv_nvdla_sdp_core_y_dpgather #(.IW(IW), .RATIO(RATIO), .CW(2)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .inp_pvld        (inp_pvld),
        .inp_data        (inp_data),
        .inp_last        (inp_last),
        .inp_prdy        (inp_prdy),
        .out_pvld        (out_pvld),
        .out_data        (out_data),
        .out_mask        (out_mask),
        .out_prdy        (out_prdy)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;
    int words_seen = 0;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- packing model / scoreboard ----------------
    logic [OW-1:0]    exp_q[$];
    logic [RATIO-1:0] exp_mask_q[$];
    logic [OW-1:0]    m_word;
    logic [RATIO-1:0] m_mask;
    int               m_cnt;

    task automatic model_clear();
        m_word = '0;
        m_mask = '0;
        m_cnt  = 0;
    endtask

    task automatic model_beat(input logic [IW-1:0] d, input logic l);
        m_word[m_cnt*IW +: IW] = d;
        m_mask[m_cnt]          = 1'b1;
        if (m_cnt == RATIO - 1 || l) begin
            exp_q.push_back(m_word);
            exp_mask_q.push_back(m_mask);
            model_clear();
        end else begin
            m_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (out_prdy) check("thru_rdy", OW'(inp_prdy), OW'(1'b1));
            if (out_pvld && !out_prdy) check("stall_rdy", OW'(inp_prdy), OW'(1'b0));
            if (out_pvld && out_prdy) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", OW'(out_pvld), OW'(1'b0));
                end else begin
                    check("sb_data", out_data, exp_q.pop_front());
                    check("sb_mask", OW'(out_mask), OW'(exp_mask_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [IW-1:0] mk(input logic [7:0] tag, input int i);
        return {tag, 24'(i), ~tag, 24'(i + 16), tag, 24'(i + 32), ~tag, 24'(i + 48)};
    endfunction

    // Entered at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_beat(input logic [IW-1:0] d, input logic l, output int waits);
        logic acc;
        inp_pvld = 1'b1;
        inp_data = d;
        inp_last = l;
        waits    = 0;
        forever begin
            #1;
            acc = inp_prdy;
            @(posedge clk);
            #1;
            if (acc) begin
                model_beat(d, l);
                break;
            end
            waits++;
            if (waits > 200) begin
                check("send_timeout", OW'(1'b0), OW'(1'b1));
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        inp_pvld = 1'b0;
        inp_last = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [IW-1:0] bt[8];
    logic          stress_done;
    int            w;
    int            total_waits;

    initial begin
        rstn        = 1'b0;
        inp_pvld    = 1'b0;
        inp_data    = '0;
        inp_last    = 1'b0;
        out_prdy    = 1'b0;
        stress_done = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pvld", OW'(out_pvld), '0);
        check("rst_mask", OW'(out_mask), '0);
        check("rst_data", out_data, '0);
        check("rst_prdy", OW'(inp_prdy), OW'(1'b1));
        rstn     = 1'b1;
        out_prdy = 1'b1;

        // Test 1: four beats back to back, word appears one cycle after A3.
        for (int i = 0; i < 4; i++) bt[i] = mk(8'hA0, i);
        total_waits = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(bt[i], 1'b0, w);
            total_waits += w;
            if (i == 2) check("t1_early_pvld", OW'(out_pvld), '0);
        end
        check("t1_prdy_waits", OW'(total_waits), '0);
        check("t1_pvld", OW'(out_pvld), OW'(1'b1));
        check("t1_data", out_data, {bt[3], bt[2], bt[1], bt[0]});
        check("t1_mask", OW'(out_mask), OW'(4'b1111));
        idle(1);
        check("t1_pvld_drop", OW'(out_pvld), '0);

        // Test 2: eight beats, output stalled three cycles after word 1.
        for (int i = 0; i < 4; i++) bt[i] = mk(8'h5A, i);
        for (int i = 0; i < 4; i++) bt[i+4] = mk(8'hB0, i);
        for (int i = 0; i < 4; i++) send_beat(bt[i], 1'b0, w);
        out_prdy = 1'b0;
        fork
            begin
                for (int i = 4; i < 8; i++) send_beat(bt[i], 1'b0, w);
            end
            begin
                repeat (3) begin
                    #1;
                    check("t2_stall_prdy", OW'(inp_prdy), '0);
                    check("t2_stall_pvld", OW'(out_pvld), OW'(1'b1));
                    check("t2_hold_data", out_data, {bt[3], bt[2], bt[1], bt[0]});
                    @(posedge clk);
                    #1;
                end
                out_prdy = 1'b1;
            end
        join
        check("t2_w2_data", out_data, {bt[7], bt[6], bt[5], bt[4]});
        check("t2_w2_mask", OW'(out_mask), OW'(4'b1111));
        idle(2);
        check("t2_words", OW'(words_seen), OW'(3));

        // Test 3: short stream closed by inp_last.
        bt[0] = mk(8'hC0, 0);
        bt[1] = mk(8'hC0, 1);
        send_beat(bt[0], 1'b0, w);
        send_beat(bt[1], 1'b1, w);
        check("t3_pvld", OW'(out_pvld), OW'(1'b1));
        check("t3_data", out_data, {{(2*IW){1'b0}}, bt[1], bt[0]});
        check("t3_mask", OW'(out_mask), OW'(4'b0011));

        // Test 4: full word, then a single last beat on the draining cycle.
        for (int i = 0; i < 4; i++) bt[i] = mk(8'hF0, i);
        bt[4] = mk(8'hD0, 0);
        for (int i = 0; i < 4; i++) send_beat(bt[i], 1'b0, w);
        check("t4_full_data", out_data, {bt[3], bt[2], bt[1], bt[0]});
        send_beat(bt[4], 1'b1, w);
        check("t4_d0_waits", OW'(w), '0);
        check("t4_pvld", OW'(out_pvld), OW'(1'b1));
        check("t4_data", out_data, {{(3*IW){1'b0}}, bt[4]});
        check("t4_mask", OW'(out_mask), OW'(4'b0001));
        idle(2);

        // Test 5: reset in the middle of a word discards it.
        for (int i = 0; i < 3; i++) send_beat(mk(8'h6C, i), 1'b0, w);
        rstn = 1'b0;
        model_clear();
        idle(1);
        check("t5_rst_pvld", OW'(out_pvld), '0);
        check("t5_rst_mask", OW'(out_mask), '0);
        check("t5_rst_data", out_data, '0);
        idle(1);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) bt[i] = mk(8'hE0, i);
        for (int i = 0; i < 3; i++) send_beat(bt[i], 1'b0, w);
        check("t5_early_pvld", OW'(out_pvld), '0);
        send_beat(bt[3], 1'b0, w);
        check("t5_pvld", OW'(out_pvld), OW'(1'b1));
        check("t5_data", out_data, {bt[3], bt[2], bt[1], bt[0]});
        check("t5_mask", OW'(out_mask), OW'(4'b1111));
        idle(2);

        // Test 6: random valid/ready stress with random stream ends.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send_beat({$urandom, $urandom, $urandom, $urandom},
                              ($urandom_range(0, 7) == 0), w);
                end
                idle(1);
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    out_prdy = ($urandom_range(0, 1) == 1);
                    @(posedge clk);
                    #1;
                end
                out_prdy = 1'b1;
            end
        join
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("t6_drain", OW'(exp_q.size()), '0);
        check("t6_words_min", OW'(words_seen >= 250), OW'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
